mmio_tx_port: RTL and testbench

Memory-mapped transmit port that sits on the minicpu data-memory bus beside the ram, answering CPU reads and writes inside a small address window. CPU stores to its data register are queued in a FIFO and drained to an external sink over a valid/ready handshake. A programmable down-counter timer raises a sticky expiry flag and interrupt line, giving CPU programs an output channel and a simple delay source.

---
 rtl/mmio_tx_port.sv | 147 ++++++++++++++
 tb/tb_mmio_tx_port.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_tx_port.sv
// mmio_tx_port: memory-mapped transmit port for the minicpu data bus.
//
// A 4-register window at BASE:
//   +0 TXDATA  write pushes into the FIFO, read returns the head (0 if empty)
//   +1 STATUS  {count[7:4], expired, overflow, full, empty}; read clears sticky flags
//   +2 TIMER   write loads the down-counter, read returns its value
//   +3         reserved, reads 0
// The FIFO drains to an external sink over out_valid/out_ready. irq mirrors the
// sticky timer-expired flag.
//
// Ports:
//   clk, rst_          clock, asynchronous active-low reset
//   addr, d_in, d_out  CPU address, write data, read data (0 unless a valid read)
//   rd_, wr_           active-low strobes
//   sel                addr lies inside the window
//   out_data/valid/ready  sink handshake, out_data is the FIFO head
//   irq                timer expired
module mmio_tx_port #(
  parameter int unsigned       ADDR_W = 8,
  parameter int unsigned       DATA_W = 8,
  parameter logic [ADDR_W-1:0] BASE   = 8'hF0,
  parameter int unsigned       DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              rd_,
  input  logic              wr_,
  output logic              sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              irq
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [DATA_W-1:0] timer_q, timer_d;
  logic              ovf_q, ovf_d;
  logic              exp_q, exp_d;

  logic [1:0]        off;
  logic              rd_ok, wr_ok;
  logic              empty, full;
  logic              push, pop, push_full;
  logic              rd_status, wr_timer;
  logic [DATA_W-1:0] status;

  // BASE is 4-aligned, so the window is a match on the upper address bits.
  assign sel   = (addr[ADDR_W-1:2] == BASE[ADDR_W-1:2]);
  assign off   = addr[1:0];
  // Both strobes low is treated as no access at all.
  assign rd_ok = sel && !rd_ && wr_;
  assign wr_ok = sel && !wr_ && rd_;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(DEPTH));
  assign out_valid = !empty;
  assign out_data  = out_valid ? mem_q[rptr_q] : '0;
  assign irq       = exp_q;

  assign pop       = out_valid && out_ready;
  // A same-cycle pop does not make room for a push into a full FIFO.
  assign push      = wr_ok && (off == 2'd0) && !full;
  assign push_full = wr_ok && (off == 2'd0) && full;
  assign rd_status = rd_ok && (off == 2'd1);
  assign wr_timer  = wr_ok && (off == 2'd2);

  always_comb begin
    status      = '0;
    status[0]   = empty;
    status[1]   = full;
    status[2]   = ovf_q;
    status[3]   = exp_q;
    status[7:4] = 4'(count_q);
  end

  always_comb begin
    d_out = '0;
    if (rd_ok) begin
      unique case (off)
        2'd0:    d_out = out_data;
        2'd1:    d_out = status;
        2'd2:    d_out = timer_q;
        default: d_out = '0;
      endcase
    end
  end

  always_comb begin
    wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Clears are applied first so a same-edge set wins.
    ovf_d = ovf_q;
    if (rd_status) ovf_d = 1'b0;
    if (push_full) ovf_d = 1'b1;

    timer_d = timer_q;
    exp_d   = exp_q;
    if (rd_status) exp_d = 1'b0;
    if (wr_timer) begin
      // A load overrides both the decrement and any expiry on this edge.
      timer_d = d_in;
      exp_d   = 1'b0;
    end else if (timer_q != '0) begin
      timer_d = timer_q - DATA_W'(1);
      if (timer_q == DATA_W'(1)) exp_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      timer_q <= '0;
      ovf_q   <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      exp_q   <= exp_d;
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= d_in;
  end

endmodule

// File: tb/tb_mmio_tx_port.sv
module tb_mmio_tx_port;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       rd_ = 1'b1;
  logic       wr_ = 1'b1;
  logic       sel;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       irq;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q [$];

  mmio_tx_port #(
    .ADDR_W(8),
    .DATA_W(8),
    .BASE  (8'hF0),
    .DEPTH (8)
  ) dut (
    .clk      (clk),
    .rst_     (rst_),
    .addr     (addr),
    .d_in     (d_in),
    .d_out    (d_out),
    .rd_      (rd_),
    .wr_      (wr_),
    .sel      (sel),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sink monitor: inputs change just after posedge, so the negedge value is what
  // the next posedge will see for the handshake.
  always @(negedge clk) begin
    if (rst_ && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL sink: unexpected word 0x%0h, expected none", out_data);
      end else begin
        check("sink", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a;
    d_in = d;
    wr_  = 1'b0;
    cyc();
    wr_  = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] e);
    addr = a;
    rd_  = 1'b0;
    #2;
    check(name, d_out, e);
    cyc();
    rd_  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and idle
    #2;
    check("rst_valid", out_valid, 0);
    #15;
    rst_ = 1'b1;
    cyc();
    check("idle_valid", out_valid, 0);
    check("idle_irq", irq, 0);
    check("idle_data", out_data, 0);
    rd_chk("rst_status", 8'hF1, 8'h01);

    // Push three words, then drain at one word per cycle
    foreach (exp_q[i]) ; // queue starts empty
    wr(8'hF0, 8'h11); exp_q.push_back(8'h11);
    wr(8'hF0, 8'h22); exp_q.push_back(8'h22);
    wr(8'hF0, 8'h33); exp_q.push_back(8'h33);
    rd_chk("status_3", 8'hF1, 8'h30);
    rd_chk("head_3", 8'hF0, 8'h11);
    out_ready = 1'b1;
    repeat (3) cyc();
    check("drained_valid", out_valid, 0);
    out_ready = 1'b0;

    // Overflow: ninth word is dropped
    for (int i = 1; i <= 9; i++) begin
      wr(8'hF0, 8'(i));
      if (i <= 8) exp_q.push_back(8'(i));
    end
    rd_chk("ovf_head", 8'hF0, 8'h01);
    rd_chk("ovf_status1", 8'hF1, 8'h86);
    rd_chk("ovf_status2", 8'hF1, 8'h82);
    out_ready = 1'b1;
    repeat (8) cyc();
    check("ovf_drained", out_valid, 0);
    out_ready = 1'b0;

    // Back-to-back push while the sink is ready: push and pop share an edge
    out_ready = 1'b1;
    wr(8'hF0, 8'hA1); exp_q.push_back(8'hA1);
    wr(8'hF0, 8'hA2); exp_q.push_back(8'hA2);
    cyc();
    check("pp_drained", out_valid, 0);
    out_ready = 1'b0;

    // Timer: load 5, irq rises after the fifth following edge
    wr(8'hF2, 8'd5);
    repeat (4) cyc();
    check("tmr_irq_early", irq, 0);
    cyc();
    check("tmr_irq", irq, 1);
    rd_chk("tmr_zero", 8'hF2, 8'h00);
    rd_chk("tmr_status", 8'hF1, 8'h09);
    check("tmr_irq_cleared", irq, 0);
    wr(8'hF2, 8'd0);
    repeat (3) cyc();
    check("tmr_load0_irq", irq, 0);

    // Collision: reload on the edge where the count would hit zero
    wr(8'hF2, 8'd3);
    cyc();
    cyc();
    wr(8'hF2, 8'd7);
    check("coll_irq", irq, 0);
    rd_chk("coll_timer", 8'hF2, 8'h07);
    wr(8'hF2, 8'd0);

    // Both strobes low: no access
    addr = 8'hF0;
    d_in = 8'hAA;
    rd_  = 1'b0;
    wr_  = 1'b0;
    #2;
    check("both_dout", d_out, 0);
    cyc();
    rd_  = 1'b1;
    wr_  = 1'b1;
    check("both_valid", out_valid, 0);

    // Window decode and ignored writes
    addr = 8'hEF;
    #1;
    check("sel_below", sel, 0);
    wr(8'hEF, 8'h55);
    rd_chk("rd_below", 8'hEF, 8'h00);
    addr = 8'hF4;
    #1;
    check("sel_above", sel, 0);
    wr(8'hF4, 8'h55);
    rd_chk("rd_above", 8'hF4, 8'h00);
    addr = 8'hF3;
    #1;
    check("sel_top", sel, 1);
    wr(8'hF3, 8'h66);
    wr(8'hF1, 8'hFF);
    rd_chk("rd_rsvd", 8'hF3, 8'h00);
    rd_chk("win_status", 8'hF1, 8'h01);
    rd_chk("win_timer", 8'hF2, 8'h00);

    // Mid-operation reset discards queued data immediately
    wr(8'hF0, 8'h5A);
    wr(8'hF0, 8'h5B);
    check("pre_rst_valid", out_valid, 1);
    rst_ = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    out_ready = 1'b1;
    cyc();
    rst_ = 1'b1;
    out_ready = 1'b0;
    rd_chk("post_rst_status", 8'hF1, 8'h01);

    check("queue_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
